axi_hs_stall_injector: RTL

//  Parametrised handshake-stall injector for NCH independent valid/ready channels.

---
 rtl/axi_stall_pkg.sv | 28 ++
 rtl/stall_lfsr.sv | 28 ++
 rtl/axi_hs_stall_injector.sv | 132 +++++++++++++
 3 files changed

// File: rtl/axi_stall_pkg.sv
// Shared types and constants for the handshake stall injector.
package axi_stall_pkg;

  typedef enum logic [1:0] {
    SM_BYPASS   = 2'd0,
    SM_RANDOM   = 2'd1,
    SM_PERIODIC = 2'd2,
    SM_FREEZE   = 2'd3
  } stall_mode_e;

  // Golden-ratio constant used to decorrelate per-channel LFSR seeds.
  localparam logic [31:0] LFSR_SEED_MIX = 32'h9E3779B9;

  // Right-shift Galois tap masks for maximal-length sequences.
  function automatic logic [63:0] lfsr_taps(input int w);
    logic [63:0] t;
    case (w)
      8:       t = 64'h0000_0000_0000_00B8;
      16:      t = 64'h0000_0000_0000_B400;
      24:      t = 64'h0000_0000_00E1_0000;
      32:      t = 64'h0000_0000_8020_0003;
      64:      t = 64'hD800_0000_0000_0000;
      default: t = 64'h0000_0000_8020_0003;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/stall_lfsr.sv
// Galois LFSR with synchronous load; an all-zero load value is replaced by 1
// so the register can never lock up.
module stall_lfsr
  import axi_stall_pkg::*;
#(
  parameter int LW = 32
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          load,
  input  logic [LW-1:0] seed,
  output logic [LW-1:0] q
);

  localparam logic [LW-1:0] TAPS = LW'(lfsr_taps(LW));

  // Load has priority over advancing; otherwise step one Galois shift per cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q <= LW'(1);
    end else if (load) begin
      q <= (seed == '0) ? LW'(1) : seed;
    end else begin
      q <= (q >> 1) ^ (q[0] ? TAPS : '0);
    end
  end

endmodule

// File: rtl/axi_hs_stall_injector.sv
// Valid/ready stall injector for NCH independent channels. Gating never
// withdraws a presented valid: once dn_valid is shown without dn_ready, a hold
// bit keeps the channel open until the handshake completes.
module axi_hs_stall_injector
  import axi_stall_pkg::*;
#(
  parameter int NCH       = 5,
  parameter int PW        = 10,
  parameter int LW        = 32,
  parameter int MAX_STALL = 64,
  parameter int CW        = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [1:0]        mode,
  input  logic [LW-1:0]     seed,
  input  logic              reseed,
  input  logic [NCH*PW-1:0] thresh,
  input  logic              clr_stats,
  input  logic [NCH-1:0]    up_valid,
  output logic [NCH-1:0]    up_ready,
  output logic [NCH-1:0]    dn_valid,
  input  logic [NCH-1:0]    dn_ready,
  output logic [NCH*CW-1:0] stall_cnt,
  output logic [NCH*CW-1:0] hs_cnt
);

  localparam int              RW       = (MAX_STALL > 0) ? $clog2(MAX_STALL + 1) : 1;
  localparam logic [RW-1:0]   RUN_LAST = (MAX_STALL > 0) ? RW'(MAX_STALL - 1) : '0;
  localparam logic [CW-1:0]   CNT_MAX  = '1;
  localparam logic            BOUNDED  = (MAX_STALL > 0);

  stall_mode_e mode_e;
  logic        started_q;
  logic        lfsr_load;

  assign mode_e    = stall_mode_e'(mode);
  // The LFSRs pick up the seed on the first cycle after reset release.
  assign lfsr_load = reseed | ~started_q;

  // Marks that the post-reset seed load has happened.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) started_q <= 1'b0;
    else       started_q <= 1'b1;
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    localparam logic [LW-1:0] CH_MIX = LW'(LFSR_SEED_MIX * i);

    logic [LW-1:0] lfsr_q;
    logic [PW-1:0] thr;
    logic [PW-1:0] pcnt_q;
    logic [RW-1:0] run_q;
    logic [CW-1:0] stall_q;
    logic [CW-1:0] hs_q;
    logic          gate_q;
    logic          hold_q;
    logic          gate_d;
    logic          open;
    logic          stalled;
    logic          hs;
    logic          force_open;
    logic          unused_lfsr;

    assign thr = thresh[i*PW +: PW];

    stall_lfsr #(.LW(LW)) u_lfsr (
      .clk  (clk),
      .rstn (rstn),
      .load (lfsr_load),
      .seed (seed ^ CH_MIX),
      .q    (lfsr_q)
    );

    // Only the low PW bits feed the random comparison.
    assign unused_lfsr = ^lfsr_q[LW-1:PW];

    assign open        = gate_q | hold_q;
    assign dn_valid[i] = up_valid[i] & open;
    assign up_ready[i] = dn_ready[i] & open;
    assign stalled     = up_valid[i] & ~open;
    assign hs          = dn_valid[i] & dn_ready[i];
    assign force_open  = BOUNDED && stalled && (run_q == RUN_LAST);

    // Next gate value by mode; the liveness bound overrides everything.
    always_comb begin
      gate_d = 1'b0;
      case (mode_e)
        SM_BYPASS:   gate_d = 1'b1;
        SM_RANDOM:   gate_d = (lfsr_q[PW-1:0] < thr);
        SM_PERIODIC: gate_d = (pcnt_q >= thr);
        SM_FREEZE:   gate_d = 1'b0;
        default:     gate_d = 1'b0;
      endcase
      if (force_open) gate_d = 1'b1;
    end

    // Gate, hold, stall-run and period state for this channel.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        gate_q <= 1'b0;
        hold_q <= 1'b0;
        run_q  <= '0;
        pcnt_q <= '0;
      end else begin
        gate_q <= gate_d;
        if (dn_valid[i] && !dn_ready[i]) hold_q <= 1'b1;
        else if (hs)                     hold_q <= 1'b0;
        run_q  <= (stalled && !force_open) ? run_q + 1'b1 : '0;
        pcnt_q <= (pcnt_q >= thr) ? '0 : pcnt_q + 1'b1;
      end
    end

    // Saturating statistics; a clear wins over a coincident increment.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        stall_q <= '0;
        hs_q    <= '0;
      end else if (clr_stats) begin
        stall_q <= '0;
        hs_q    <= '0;
      end else begin
        if (stalled && stall_q != CNT_MAX) stall_q <= stall_q + 1'b1;
        if (hs && hs_q != CNT_MAX)         hs_q    <= hs_q + 1'b1;
      end
    end

    assign stall_cnt[i*CW +: CW] = stall_q;
    assign hs_cnt[i*CW +: CW]    = hs_q;
  end

endmodule
